ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_sync_edge.sv | 37 +++
 rtl/ps2_host_tx.sv | 199 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame geometry and the odd-parity helper.
// Both the host transmitter and the keyboard receiver use this package.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_state_e;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;

    function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for an asynchronous PS/2 line plus a falling-edge strobe
// (previous synchronized value 1, current 0).
module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Idle PS/2 lines float high, so reset to 1 to avoid a false edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync = sync_q;
    assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues a request-to-send, shifts out
// one byte with odd parity and stop bit on device clock falling edges, then checks the ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(FRAME_BITS + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(DATA_BITS - 1);

    ps2_state_e       state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             dmeta_q, dmeta_d;
    logic             dsync_q, dsync_d;

    logic clk_sync;
    logic clk_fall;

    ps2_sync_edge u_clk_sync (
        .clk   (clk),
        .rst_n (reset),
        .din   (ps2_clk_in),
        .sync  (clk_sync),
        .fall  (clk_fall)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        dmeta_d   = ps2_data_in;
        dsync_d   = dmeta_q;

        case (state_q)
            ST_IDLE: begin
                ready_d   = 1'b1;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid && ready_q) begin
                    data_d   = tx_data;
                    ready_d  = 1'b0;
                    clk_oe_d = 1'b1;
                    cnt_d    = '0;
                    idx_d    = '0;
                    state_d  = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                if (cnt_q == INHIBIT_LAST) begin
                    // Start bit goes out as the clock is released.
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_REQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                if (cnt_q == TIMEOUT_LAST) begin
                    // Device went quiet: abandon the frame ahead of any same-cycle edge.
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    error_d   = 1'b1;
                    ready_d   = 1'b1;
                    cnt_d     = '0;
                    idx_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    case (state_q)
                        ST_REQ: begin
                            if (clk_fall) begin
                                data_oe_d = ~data_q[0];
                                idx_d     = IDX_W'(1);
                                state_d   = ST_DATA;
                            end
                        end
                        ST_DATA: begin
                            if (clk_fall) begin
                                data_oe_d = ~data_q[idx_q[2:0]];
                                idx_d     = idx_q + IDX_W'(1);
                                if (idx_q == LAST_DATA_IDX) begin
                                    state_d = ST_PARITY;
                                end
                            end
                        end
                        ST_PARITY: begin
                            if (clk_fall) begin
                                data_oe_d = ~odd_parity(data_q);
                                idx_d     = idx_q + IDX_W'(1);
                                state_d   = ST_STOP;
                            end
                        end
                        ST_STOP: begin
                            if (clk_fall) begin
                                data_oe_d = 1'b0;
                                idx_d     = idx_q + IDX_W'(1);
                                state_d   = ST_ACK;
                            end
                        end
                        ST_ACK: begin
                            if (clk_fall) begin
                                idx_d = '0;
                                if (!dsync_q) begin
                                    state_d = ST_WAIT_IDLE;
                                end else begin
                                    error_d = 1'b1;
                                    ready_d = 1'b1;
                                    cnt_d   = '0;
                                    state_d = ST_IDLE;
                                end
                            end
                        end
                        ST_WAIT_IDLE: begin
                            if (clk_sync && dsync_q) begin
                                done_d  = 1'b1;
                                ready_d = 1'b1;
                                cnt_d   = '0;
                                idx_d   = '0;
                                state_d = ST_IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            dmeta_q   <= 1'b1;
            dsync_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            error_q   <= error_d;
            dmeta_q   <= dmeta_d;
            dsync_q   <= dsync_d;
        end
    end

    assign tx_ready    = ready_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = done_q;
    assign tx_error    = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a PS/2 device model clocks frames out of the host,
// expected done/error events are queued at stimulus time and checked by a pulse monitor.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 2000;
    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, clk_oe, data_oe, tx_done, tx_error;
    logic       dev_clk_rel = 1'b1;
    logic       dev_data_rel = 1'b1;
    logic       ps2_clk_in, ps2_data_in;

    assign ps2_clk_in  = ~clk_oe & dev_clk_rel;
    assign ps2_data_in = ~data_oe & dev_data_rel;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (clk_oe),
        .ps2_data_oe (data_oe),
        .tx_done     (tx_done),
        .tx_error    (tx_error)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit         is_err;
        bit         has_frame;
        logic [9:0] frame;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [9:0] dev_frame = '0;
    int         inh_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic expect_evt(input bit is_err, input bit has_frame, input logic [9:0] frame);
        exp_t e;
        e.is_err    = is_err;
        e.has_frame = has_frame;
        e.frame     = frame;
        exp_q.push_back(e);
    endtask

    // Pulse monitor: every done/error pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset && (tx_done || tx_error)) begin
            check("done_error_exclusive", 32'(tx_done & tx_error), 32'(0));
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'({tx_done, tx_error}), 32'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_kind_error", 32'(tx_error), 32'(mon_e.is_err));
                if (mon_e.has_frame) begin
                    check("frame_bits", 32'(dev_frame), 32'(mon_e.frame));
                end
                check("ready_and_lines_released", 32'({tx_ready, clk_oe, data_oe}), 32'(3'b100));
            end
        end
    end

    // Inhibit monitor: each clock-low request lasts INH cycles and ends with the start bit.
    always @(negedge clk) begin
        if (clk_oe) begin
            inh_run <= inh_run + 1;
        end else if (inh_run != 0) begin
            check("inhibit_len", 32'(inh_run), 32'(INH));
            check("start_bit_driven", 32'(data_oe), 32'(1));
            inh_run <= 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, n_checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic dev_run(input bit do_ack, input int stop_after);
        int w;
        logic [3:0] bi;
        w = 0;
        while (!clk_oe && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (!clk_oe) begin
            check("dev_wait_inhibit", 32'(clk_oe), 32'(1));
            return;
        end
        w = 0;
        while (clk_oe && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (clk_oe) begin
            check("dev_wait_release", 32'(clk_oe), 32'(0));
            return;
        end
        dev_frame = '0;
        repeat (HALF) @(negedge clk);
        for (int e = 1; e <= 11; e++) begin
            if (e == 11 && do_ack) begin
                dev_data_rel = 1'b0;
                repeat (5) @(negedge clk);
            end
            dev_clk_rel = 1'b0;
            repeat (HALF) @(negedge clk);
            if (e <= 10) begin
                bi = 4'(e - 1);
                dev_frame[bi] = ps2_data_in;
            end
            dev_clk_rel = 1'b1;
            repeat (HALF) @(negedge clk);
            if (e == stop_after) return;
        end
        dev_data_rel = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        int w;
        w = 0;
        @(negedge clk);
        while (!tx_ready && w < 5000) begin
            @(negedge clk);
            w++;
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("accept_drops_ready", 32'(tx_ready), 32'(0));
    endtask

    task automatic drive_b2b();
        int w;
        w = 0;
        @(negedge clk);
        while (!tx_ready && w < 5000) begin
            @(negedge clk);
            w++;
        end
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h0F;
        w = 0;
        while (!tx_ready && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check("b2b_ready_only_with_done", 32'(tx_done), 32'(1));
        @(negedge clk);
        tx_valid = 1'b0;
        check("b2b_second_accepted", 32'(tx_ready), 32'(0));
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        check("rst_tx_ready", 32'(tx_ready), 32'(1));
        check("rst_clk_oe", 32'(clk_oe), 32'(0));
        check("rst_data_oe", 32'(data_oe), 32'(0));
        check("rst_tx_done", 32'(tx_done), 32'(0));
        check("rst_tx_error", 32'(tx_error), 32'(0));
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // 0xED: bits 1,0,1,1,0,1,1,1 parity 1 stop 1
        expect_evt(1'b0, 1'b1, 10'h3ED);
        fork
            send_byte(8'hED);
            dev_run(1'b1, 0);
        join
        repeat (20) @(negedge clk);

        // 0xF4: bits 0,0,1,0,1,1,1,1 parity 0 stop 1
        expect_evt(1'b0, 1'b1, 10'h2F4);
        fork
            send_byte(8'hF4);
            dev_run(1'b1, 0);
        join
        repeat (20) @(negedge clk);

        // 0x12 without ACK: parity 1, error pulse
        expect_evt(1'b1, 1'b1, 10'h312);
        fork
            send_byte(8'h12);
            dev_run(1'b0, 0);
        join
        repeat (20) @(negedge clk);

        // Silent device: error TMO cycles after clock release
        expect_evt(1'b1, 1'b0, 10'h000);
        send_byte(8'h3C);
        k = 0;
        while (clk_oe && k < 5000) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        while (!tx_error && k < 3 * TMO) begin
            @(negedge clk);
            k++;
        end
        check("timeout_latency", 32'(k), 32'(TMO));
        check("timeout_lines_released", 32'({clk_oe, data_oe}), 32'(0));
        repeat (20) @(negedge clk);

        // Reset after edge 4 of 0xAA, then a clean 0xAA
        fork
            send_byte(8'hAA);
            dev_run(1'b1, 4);
        join
        check("midframe_busy", 32'(tx_ready), 32'(0));
        reset = 1'b0;
        #1;
        check("abort_clk_oe", 32'(clk_oe), 32'(0));
        check("abort_data_oe", 32'(data_oe), 32'(0));
        check("abort_ready", 32'(tx_ready), 32'(1));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (300) @(negedge clk);
        expect_evt(1'b0, 1'b1, 10'h3AA);
        fork
            send_byte(8'hAA);
            dev_run(1'b1, 0);
        join
        repeat (20) @(negedge clk);

        // Back-to-back 0x55 then 0x0F with tx_valid held
        expect_evt(1'b0, 1'b1, 10'h355);
        expect_evt(1'b0, 1'b1, 10'h30F);
        fork
            drive_b2b();
            begin
                dev_run(1'b1, 0);
                dev_run(1'b1, 0);
            end
        join
        repeat (50) @(negedge clk);

        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
